demux16_stream: RTL and testbench



---
 rtl/demux16_stream_if.sv | 33 +++
 rtl/demux16_stream.sv | 77 +++++++
 tb/tb_demux16_stream.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/demux16_stream_if.sv
// Stream bundle for demux16_stream: one steered input stream, two output streams, occupancy counts.
// Latency: none (signal bundle only).
// Backpressure: carried by in_ready / outA_ready / outB_ready.
// Ports: in/select/in_valid/in_ready (producer), outA*/outB* (consumers), countA/countB (status).
interface demux16_stream_if #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 2
);
    logic [WIDTH-1:0] in;
    logic             select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] outA;
    logic             outA_valid;
    logic             outA_ready;
    logic [WIDTH-1:0] outB;
    logic             outB_valid;
    logic             outB_ready;
    logic [CNTW-1:0]  countA;
    logic [CNTW-1:0]  countB;

    // Environment side: drives the producer and both consumers.
    modport master (
        output in, select, in_valid, outA_ready, outB_ready,
        input  in_ready, outA, outA_valid, outB, outB_valid, countA, countB
    );

    // Demux side.
    modport slave (
        input  in, select, in_valid, outA_ready, outB_ready,
        output in_ready, outA, outA_valid, outB, outB_valid, countA, countB
    );
endinterface

// File: rtl/demux16_stream.sv
// Buffered 1-to-2 word demux: each word goes to FIFO A (select=0) or FIFO B (select=1).
// Latency: 1 cycle from accepted push to outX_valid; no combinational in->out path.
// Backpressure: in_ready reflects only the selected FIFO's registered count (full refuses, no pop bypass).
// Ports: clk, reset (sync, active-high), bus (slave view of demux16_stream_if).
module demux16_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    demux16_stream_if.slave      bus
);
    localparam int              PW   = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] ONE  = CNTW'(1);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_a, rd_a, wr_b, rd_b;
    logic [CNTW-1:0]  cnt_a, cnt_b;
    logic             push_a, push_b, pop_a, pop_b;
    logic             accept;

    // Ready depends on registered counts only, so a full FIFO stays closed
    // even when its consumer is draining it in the same cycle.
    assign bus.in_ready = bus.select ? (cnt_b < FULL) : (cnt_a < FULL);
    assign accept       = bus.in_valid && bus.in_ready;

    assign push_a = accept && !bus.select;
    assign push_b = accept &&  bus.select;
    assign pop_a  = (cnt_a != '0) && bus.outA_ready;
    assign pop_b  = (cnt_b != '0) && bus.outB_ready;

    // Storage is not reset; the counts decide what is visible.
    always_ff @(posedge clk) begin
        if (!reset && push_a) mem_a[wr_a] <= bus.in;
        if (!reset && push_b) mem_b[wr_b] <= bus.in;
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_a  <= '0;
            rd_a  <= '0;
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (push_a) wr_a <= wr_a + 1'b1;
            if (pop_a)  rd_a <= rd_a + 1'b1;
            if (push_b) wr_b <= wr_b + 1'b1;
            if (pop_b)  rd_b <= rd_b + 1'b1;

            case ({push_a, pop_a})
                2'b10:   cnt_a <= cnt_a + ONE;
                2'b01:   cnt_a <= cnt_a - ONE;
                default: cnt_a <= cnt_a;
            endcase

            case ({push_b, pop_b})
                2'b10:   cnt_b <= cnt_b + ONE;
                2'b01:   cnt_b <= cnt_b - ONE;
                default: cnt_b <= cnt_b;
            endcase
        end
    end

    // Head words are forced to zero when empty so stale storage never shows.
    assign bus.outA       = (cnt_a != '0) ? mem_a[rd_a] : '0;
    assign bus.outB       = (cnt_b != '0) ? mem_b[rd_b] : '0;
    assign bus.outA_valid = (cnt_a != '0);
    assign bus.outB_valid = (cnt_b != '0);
    assign bus.countA     = cnt_a;
    assign bus.countB     = cnt_b;
endmodule

// File: tb/tb_demux16_stream.sv
// Testbench for demux16_stream: directed vector table, random-ready stream, mid-stream reset.
module tb_demux16_stream;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    demux16_stream_if #(.WIDTH(16), .CNTW(2)) bus ();

    demux16_stream #(.WIDTH(16), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle plus the outputs expected before the next rising edge.
    typedef struct {
        logic        sel;
        logic        vld;
        logic [15:0] din;
        logic        ra;
        logic        rb;
        logic        e_rdy;
        logic        e_va;
        logic [15:0] e_a;
        logic        e_vb;
        logic [15:0] e_b;
        logic [1:0]  e_ca;
        logic [1:0]  e_cb;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];

    function automatic vec_t mk(input logic sel, input logic vld, input logic [15:0] din,
                                input logic ra, input logic rb, input logic e_rdy,
                                input logic e_va, input logic [15:0] e_a,
                                input logic e_vb, input logic [15:0] e_b,
                                input logic [1:0] e_ca, input logic [1:0] e_cb);
        vec_t v;
        v.sel = sel; v.vld = vld; v.din = din; v.ra = ra; v.rb = rb;
        v.e_rdy = e_rdy; v.e_va = e_va; v.e_a = e_a; v.e_vb = e_vb; v.e_b = e_b;
        v.e_ca = e_ca; v.e_cb = e_cb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic vld, input logic [15:0] din,
                         input logic ra, input logic rb);
        bus.select     = sel;
        bus.in_valid   = vld;
        bus.in         = din;
        bus.outA_ready = ra;
        bus.outB_ready = rb;
    endtask

    int q_a [$];
    int q_b [$];

    initial begin
        //           sel vld din      ra rb | rdy va outA     vb outB     cA cB
        // idle after reset, both selects
        vt[0]  = mk(0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vt[1]  = mk(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vt[2]  = mk(0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // 0x1234 to A, 0xABCD to B, consumers ready
        vt[3]  = mk(0, 1, 16'h1234, 1, 1,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vt[4]  = mk(1, 1, 16'hABCD, 1, 1,  1, 1, 16'h1234, 0, 16'h0000, 1, 0);
        vt[5]  = mk(0, 0, 16'h0000, 1, 1,  1, 0, 16'h0000, 1, 16'hABCD, 0, 1);
        vt[6]  = mk(0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // A stalled: fill A, third word refused, re-steer to B, then drain A
        vt[7]  = mk(0, 1, 16'h0001, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vt[8]  = mk(0, 1, 16'h0002, 0, 0,  1, 1, 16'h0001, 0, 16'h0000, 1, 0);
        vt[9]  = mk(0, 1, 16'h0003, 0, 0,  0, 1, 16'h0001, 0, 16'h0000, 2, 0);
        vt[10] = mk(1, 1, 16'h00B0, 0, 0,  1, 1, 16'h0001, 0, 16'h0000, 2, 0);
        vt[11] = mk(0, 0, 16'h0000, 1, 0,  0, 1, 16'h0001, 1, 16'h00B0, 2, 1);
        vt[12] = mk(0, 0, 16'h0000, 1, 1,  1, 1, 16'h0002, 1, 16'h00B0, 1, 1);
        vt[13] = mk(0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // push and pop on A in the same cycle at count 1
        vt[14] = mk(0, 1, 16'h1111, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vt[15] = mk(0, 1, 16'h5555, 1, 0,  1, 1, 16'h1111, 0, 16'h0000, 1, 0);
        vt[16] = mk(0, 0, 16'h0000, 0, 0,  1, 1, 16'h5555, 0, 16'h0000, 1, 0);
        vt[17] = mk(0, 0, 16'h0000, 1, 0,  1, 1, 16'h5555, 0, 16'h0000, 1, 0);
        vt[18] = mk(0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // full A refuses a push even while being popped
        vt[19] = mk(0, 1, 16'h00A1, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vt[20] = mk(0, 1, 16'h00A2, 0, 0,  1, 1, 16'h00A1, 0, 16'h0000, 1, 0);
        vt[21] = mk(0, 1, 16'h00A3, 1, 0,  0, 1, 16'h00A1, 0, 16'h0000, 2, 0);
        vt[22] = mk(0, 0, 16'h0000, 1, 0,  1, 1, 16'h00A2, 0, 16'h0000, 1, 0);
        vt[23] = mk(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // ready with nothing queued has no effect
        vt[24] = mk(0, 0, 16'h0000, 1, 1,  1, 0, 16'h0000, 0, 16'h0000, 0, 0);

        reset = 1'b1;
        drive(0, 0, 16'h0000, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table: drive at the falling edge, check just after, rising edge commits.
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].sel, vt[i].vld, vt[i].din, vt[i].ra, vt[i].rb);
            #1;
            chk($sformatf("v%0d in_ready", i),   32'(bus.in_ready),   32'(vt[i].e_rdy));
            chk($sformatf("v%0d outA_valid", i), 32'(bus.outA_valid), 32'(vt[i].e_va));
            chk($sformatf("v%0d outA", i),       32'(bus.outA),       32'(vt[i].e_a));
            chk($sformatf("v%0d outB_valid", i), 32'(bus.outB_valid), 32'(vt[i].e_vb));
            chk($sformatf("v%0d outB", i),       32'(bus.outB),       32'(vt[i].e_b));
            chk($sformatf("v%0d countA", i),     32'(bus.countA),     32'(vt[i].e_ca));
            chk($sformatf("v%0d countB", i),     32'(bus.countB),     32'(vt[i].e_cb));
            @(negedge clk);
        end

        // Alternating 20-word stream with random consumer readiness, scoreboarded per channel.
        begin
            int sent = 0;
            int got_a = 0;
            int got_b = 0;
            int cyc = 0;
            logic sel, ra, rb, exp_rdy;
            while ((sent < 20 || q_a.size() != 0 || q_b.size() != 0) && cyc < 500) begin
                sel = sent[0];
                ra  = 1'($urandom_range(0, 1));
                rb  = 1'($urandom_range(0, 1));
                drive(sel, sent < 20, 16'(sent), ra, rb);
                #1;
                exp_rdy = sel ? (q_b.size() < 2) : (q_a.size() < 2);
                chk("rs in_ready",   32'(bus.in_ready),   32'(exp_rdy));
                chk("rs outA_valid", 32'(bus.outA_valid), 32'(q_a.size() != 0));
                chk("rs outB_valid", 32'(bus.outB_valid), 32'(q_b.size() != 0));
                chk("rs countA",     32'(bus.countA),     32'(q_a.size()));
                chk("rs countB",     32'(bus.countB),     32'(q_b.size()));
                if (q_a.size() != 0 && ra) begin
                    chk("rs outA word", 32'(bus.outA), 32'(q_a.pop_front()));
                    got_a++;
                end
                if (q_b.size() != 0 && rb) begin
                    chk("rs outB word", 32'(bus.outB), 32'(q_b.pop_front()));
                    got_b++;
                end
                if (sent < 20 && exp_rdy) begin
                    if (sel) q_b.push_back(sent);
                    else     q_a.push_back(sent);
                    sent++;
                end
                cyc++;
                @(negedge clk);
            end
            chk("rs completed in budget", 32'(cyc < 500), 32'(1));
            chk("rs words on A", 32'(got_a), 32'(10));
            chk("rs words on B", 32'(got_b), 32'(10));
        end

        // Mid-stream reset with countA=2, countB=1; a push offered during reset is dropped.
        drive(0, 1, 16'hC001, 0, 0);
        @(negedge clk);
        drive(0, 1, 16'hC002, 0, 0);
        @(negedge clk);
        drive(1, 1, 16'hC003, 0, 0);
        @(negedge clk);
        drive(1, 0, 16'h0000, 0, 0);
        #1;
        chk("pre-reset countA", 32'(bus.countA), 32'(2));
        chk("pre-reset countB", 32'(bus.countB), 32'(1));
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, 16'hDEAD, 1, 1);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 16'h0000, 0, 0);
        #1;
        chk("post-reset countA",     32'(bus.countA),     32'(0));
        chk("post-reset countB",     32'(bus.countB),     32'(0));
        chk("post-reset outA_valid", 32'(bus.outA_valid), 32'(0));
        chk("post-reset outB_valid", 32'(bus.outB_valid), 32'(0));
        chk("post-reset outA",       32'(bus.outA),       32'(0));
        chk("post-reset outB",       32'(bus.outB),       32'(0));
        @(negedge clk);
        drive(1, 1, 16'h7777, 0, 0);
        @(negedge clk);
        drive(1, 0, 16'h0000, 0, 0);
        #1;
        chk("post-reset outB_valid after push", 32'(bus.outB_valid), 32'(1));
        chk("post-reset first outB",            32'(bus.outB),       32'h7777);
        chk("post-reset countB after push",     32'(bus.countB),     32'(1));
        @(negedge clk);
        drive(1, 0, 16'h0000, 0, 1);
        @(negedge clk);
        #1;
        chk("final countB", 32'(bus.countB), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
